wbvgacapture: RTL

Video frame capture engine: the write-side counterpart of the frame-buffer VGA reader. It accepts a pixel stream with VGA sync signals and writes each visible pixel into memory as one 32-bit word over a pipelined Wishbone master. A small internal FIFO absorbs bus stalls. It sits between a video source, such as a VGA generator or camera front end synchronous to `i_clk`, and a Wishbone memory such as memdev.

---
 rtl/wbvgacapture.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/wbvgacapture.sv
// Video frame capture engine: writes each visible pixel of a VGA-timed
// stream into memory as one 32-bit word over a pipelined Wishbone master,
// with a small FIFO absorbing bus stalls.
module wbvgacapture #(
    parameter int AW     = 24,
    parameter int FW     = 13,
    parameter int LW     = 11,
    parameter int LGFIFO = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic [AW-1:0] i_base_addr,
    input  logic [FW-1:0] i_width,
    input  logic [LW-1:0] i_height,
    input  logic [FW-1:0] i_line_words,
    input  logic          i_vga_vsync,
    input  logic          i_vga_de,
    input  logic [7:0]    i_vga_red,
    input  logic [7:0]    i_vga_grn,
    input  logic [7:0]    i_vga_blu,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    output logic          o_interrupt,
    output logic          o_overflow,
    output logic          o_err
);

    localparam int DEPTH = 1 << LGFIFO;
    localparam int EW    = 1 + AW + 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DROP
    } state_t;

    state_t state, state_next;

    logic          vsync_q, de_q;
    logic [FW-1:0] x, x_eff;
    logic [LW-1:0] y, y_eff;
    logic [AW-1:0] line_addr, line_eff, pix_addr;
    logic          frame_start, de_fall, in_window, pix_last;

    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [EW-1:0]   fifo_head;
    logic [LGFIFO:0] wr_ptr, rd_ptr, fifo_fill;
    logic            fifo_empty, fifo_full;

    logic        bus_err, bus_ack, issue, load, push_req, push, drop;
    logic [15:0] outstanding, out_next, last_cnt;
    logic        last_wait, last_hit, stb_last;

    assign o_wb_we  = 1'b1;
    assign o_wb_sel = 4'hF;

    // Frame/line event detection and the effective (post frame-start) counters.
    always_comb begin
        frame_start = vsync_q & ~i_vga_vsync;
        de_fall     = de_q & ~i_vga_de;
        x_eff       = frame_start ? '0 : x;
        y_eff       = frame_start ? '0 : y;
        line_eff    = frame_start ? i_base_addr : line_addr;
        in_window   = (x_eff < i_width) && (y_eff < i_height);
        pix_addr    = line_eff + AW'(x_eff);
        pix_last    = (x_eff == i_width - FW'(1)) && (y_eff == i_height - LW'(1));
    end

    // FIFO status, bus handshakes and push/pop decisions.
    always_comb begin
        fifo_fill  = wr_ptr - rd_ptr;
        fifo_empty = (fifo_fill == '0);
        fifo_full  = fifo_fill[LGFIFO];
        fifo_head  = fifo_mem[rd_ptr[LGFIFO-1:0]];
        bus_err    = i_wb_err & o_wb_cyc;
        bus_ack    = i_wb_ack & o_wb_cyc;
        issue      = o_wb_stb & ~i_wb_stall;
        load       = (~o_wb_stb | ~i_wb_stall) & ~fifo_empty & ~bus_err;
        push_req   = i_vga_de & in_window & (state == S_CAPTURE) & ~bus_err;
        push       = push_req & (~fifo_full | load);
        drop       = push_req & fifo_full & ~load;
        out_next   = outstanding + 16'(issue) - 16'(bus_ack);
        last_hit   = bus_ack & last_wait & (last_cnt == 16'd1);
    end

    // Pixel position and line base address tracking.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vsync_q   <= 1'b0;
            de_q      <= 1'b0;
            x         <= '0;
            y         <= '0;
            line_addr <= '0;
        end else begin
            vsync_q <= i_vga_vsync;
            de_q    <= i_vga_de;
            if (i_vga_de) begin
                x         <= (x_eff == '1) ? x_eff : x_eff + FW'(1);
                y         <= y_eff;
                line_addr <= line_eff;
            end else if (de_fall && !frame_start) begin
                x         <= '0;
                y         <= (y == '1) ? y : y + LW'(1);
                line_addr <= line_addr + AW'(i_line_words);
            end else begin
                x         <= x_eff;
                y         <= y_eff;
                line_addr <= line_eff;
            end
        end
    end

    // FIFO storage; push is already suppressed during a bus error.
    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr[LGFIFO-1:0]] <= {pix_last, pix_addr, 8'h00,
                                             i_vga_red, i_vga_grn, i_vga_blu};
    end

    // FIFO pointers, flushed on bus error.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus_err) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Wishbone master: output register, outstanding count, last-ack tracking.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            stb_last    <= 1'b0;
            outstanding <= '0;
            last_wait   <= 1'b0;
            last_cnt    <= '0;
            o_interrupt <= 1'b0;
        end else begin
            o_interrupt <= last_hit;
            if (bus_err) begin
                o_wb_cyc    <= 1'b0;
                o_wb_stb    <= 1'b0;
                outstanding <= '0;
                last_wait   <= 1'b0;
            end else begin
                outstanding <= out_next;
                if (load) begin
                    {stb_last, o_wb_addr, o_wb_data} <= fifo_head;
                    o_wb_stb <= 1'b1;
                    o_wb_cyc <= 1'b1;
                end else if (issue) begin
                    o_wb_stb <= 1'b0;
                end
                if (!o_wb_stb && fifo_empty && outstanding == '0)
                    o_wb_cyc <= 1'b0;
                // Acks return in order, so the last entry's ack is the
                // out_next-th ack counted from the cycle it is issued.
                if (issue && stb_last) begin
                    last_wait <= 1'b1;
                    last_cnt  <= out_next;
                end else if (last_hit) begin
                    last_wait <= 1'b0;
                end else if (bus_ack && last_wait) begin
                    last_cnt <= last_cnt - 16'd1;
                end
            end
        end
    end

    // Sticky overflow and bus-error flags, cleared at frame start.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            if (frame_start)
                o_overflow <= 1'b0;
            else if (drop)
                o_overflow <= 1'b1;
            if (frame_start)
                o_err <= 1'b0;
            else if (bus_err)
                o_err <= 1'b1;
        end
    end

    // Frame state register.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Frame state next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (frame_start && i_en)
                    state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (bus_err)
                    state_next = S_DROP;
                else if (frame_start)
                    state_next = S_CAPTURE;
                else if (last_hit)
                    state_next = S_IDLE;
            end
            S_DROP: begin
                if (!o_wb_cyc)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
